text_renderer: RTL

TEXT_RENDERER -- requirements
Module: text_renderer

---
 rtl/text_renderer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/text_renderer.sv
// Walks a string held in a synchronous text buffer and hands each printable glyph to a
// downstream character renderer. Optional line wrapping is enabled by defining TEXT_WRAP_EN.
module text_renderer #(
  parameter int FONT_WIDTH   = 8,
  parameter int FONT_HEIGHT  = 8,
  parameter int CHAR_SPACING = 1,
  parameter int LINE_SPACING = 1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] text_len,
  input  logic [9:0] origin_x,
  input  logic [8:0] origin_y,
  input  logic [3:0] size,
  input  logic [9:0] max_x,
  output logic [7:0] text_addr,
  input  logic [7:0] text_char,
  output logic [7:0] char_code,
  output logic [9:0] char_x,
  output logic [8:0] char_y,
  output logic [3:0] char_size,
  output logic       char_enable,
  input  logic       char_finished,
  output logic       busy,
  output logic       done,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    DRAW   = 3'd3,
    GAP    = 3'd4,
    FINISH = 3'd5
  } state_t;

  localparam logic [12:0] SCREEN_H = 13'd480;

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  len_q, len_d;
  logic [9:0]  ox_q, ox_d;
  logic [3:0]  size_q, size_d;
  logic [9:0]  maxx_q, maxx_d;
  logic [10:0] cur_x_q, cur_x_d;
  logic [9:0]  cur_y_q, cur_y_d;
  logic [7:0]  code_q, code_d;
  logic [9:0]  cx_q, cx_d;
  logic [8:0]  cy_q, cy_d;
  logic [3:0]  csize_q, csize_d;
  logic        done_q, done_d;
`ifdef TEXT_WRAP_EN
  logic        wrapped_q, wrapped_d;
`endif

  logic [11:0] glyph_w, glyph_h, adv, line_adv;
  logic [12:0] x_end, y_end, x_sum, y_sum;
  logic [10:0] x_next;
  logic [9:0]  y_next;
  logic        fit_x, fit_y, last_char, step;

  assign glyph_w  = 12'(size_q) * 12'(FONT_WIDTH);
  assign glyph_h  = 12'(size_q) * 12'(FONT_HEIGHT);
  assign adv      = 12'(size_q) * 12'(FONT_WIDTH + CHAR_SPACING);
  assign line_adv = 12'(size_q) * 12'(FONT_HEIGHT + LINE_SPACING);

  assign x_end = 13'(cur_x_q) + 13'(glyph_w);
  assign y_end = 13'(cur_y_q) + 13'(glyph_h);
  assign fit_x = x_end <= {3'b000, maxx_q};
  assign fit_y = y_end <= SCREEN_H;

  // Cursors saturate instead of wrapping so a run-away line can never alias back on screen.
  assign x_sum  = 13'(cur_x_q) + 13'(adv);
  assign y_sum  = 13'(cur_y_q) + 13'(line_adv);
  assign x_next = (|x_sum[12:11]) ? 11'h7FF : x_sum[10:0];
  assign y_next = (|y_sum[12:10]) ? 10'h3FF : y_sum[9:0];

  assign last_char = ({1'b0, idx_q} + 9'd1) == {1'b0, len_q};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    ox_d    = ox_q;
    size_d  = size_q;
    maxx_d  = maxx_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    code_d  = code_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    csize_d = csize_q;
    done_d  = (state_q == FINISH);
    step    = 1'b0;
`ifdef TEXT_WRAP_EN
    wrapped_d = wrapped_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = text_len;
          ox_d    = origin_x;
          size_d  = (size == 4'd0) ? 4'd1 : size;
          maxx_d  = max_x;
          cur_x_d = {1'b0, origin_x};
          cur_y_d = {1'b0, origin_y};
          idx_d   = 8'd0;
          state_d = (text_len == 8'd0) ? FINISH : FETCH;
        end
      end
      FETCH: begin
        state_d = DECODE;
`ifdef TEXT_WRAP_EN
        wrapped_d = 1'b0;
`endif
      end
      DECODE: begin
        if (text_char == 8'h0A) begin
          cur_x_d = {1'b0, ox_q};
          cur_y_d = y_next;
          step    = 1'b1;
        end else if (text_char == 8'h20) begin
          cur_x_d = x_next;
          step    = 1'b1;
        end else if (fit_x && fit_y) begin
          code_d  = text_char;
          cx_d    = cur_x_q[9:0];
          cy_d    = cur_y_q[8:0];
          csize_d = size_q;
          state_d = DRAW;
`ifdef TEXT_WRAP_EN
        end else if (!fit_x && !wrapped_q) begin
          // Buffer output is still addressed by idx, so the same glyph is re-tried next cycle.
          cur_x_d   = {1'b0, ox_q};
          cur_y_d   = y_next;
          wrapped_d = 1'b1;
`endif
        end else begin
          cur_x_d = x_next;
          step    = 1'b1;
        end
      end
      DRAW: begin
        if (char_finished) begin
          cur_x_d = x_next;
          state_d = GAP;
        end
      end
      GAP:     step    = 1'b1;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (step) begin
      if (last_char) begin
        state_d = FINISH;
      end else begin
        idx_d   = idx_q + 8'd1;
        state_d = FETCH;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      ox_q    <= '0;
      size_q  <= '0;
      maxx_q  <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      code_q  <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      csize_q <= '0;
      done_q  <= 1'b0;
`ifdef TEXT_WRAP_EN
      wrapped_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      ox_q    <= ox_d;
      size_q  <= size_d;
      maxx_q  <= maxx_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      code_q  <= code_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      csize_q <= csize_d;
      done_q  <= done_d;
`ifdef TEXT_WRAP_EN
      wrapped_q <= wrapped_d;
`endif
    end
  end

  // char_enable/busy decode straight from state so an async reset drops them at once.
  assign char_enable = (state_q == DRAW);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign text_addr   = idx_q;
  assign char_code   = code_q;
  assign char_x      = cx_q;
  assign char_y      = cy_q;
  assign char_size   = csize_q;
  assign dbg_state   = state_q;

endmodule
